// File: rtl/edge_gen_if.sv
// Request/level bundle between control logic and the edge_gen serial driver.
interface edge_gen_if;
  logic rise_req_i;
  logic fall_req_i;
  logic a_o;
  logic busy_o;
  logic pend_o;
  logic drop_o;

  modport master (
    output rise_req_i, fall_req_i,
    input  a_o, busy_o, pend_o, drop_o
  );

  modport slave (
    input  rise_req_i, fall_req_i,
    output a_o, busy_o, pend_o, drop_o
  );
endinterface

// File: rtl/edge_gen.sv
// Serial level generator: turns rise/fall request pulses into a registered level
// with enforced minimum high/low dwell, one-deep opposite-direction pending slot.
module edge_gen #(
  parameter int MIN_HIGH = 3,
  parameter int MIN_LOW  = 2,
  parameter int CNT_W    = $clog2((MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW) + 1
) (
  input  logic       clk,
  input  logic       reset,
  edge_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    LOW_STABLE,
    HIGH_HOLD,
    HIGH_STABLE,
    LOW_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;

  logic rise_only, fall_only, both;

  assign both      = bus.rise_req_i &  bus.fall_req_i;
  assign rise_only = bus.rise_req_i & ~bus.fall_req_i;
  assign fall_only = bus.fall_req_i & ~bus.rise_req_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    pend_d  = pend_q;
    drop_d  = both;

    case (state_q)
      LOW_STABLE: begin
        if (rise_only) begin
          a_d     = 1'b1;
          state_d = HIGH_HOLD;
          cnt_d   = HIGH_LOAD;
        end
      end

      HIGH_STABLE: begin
        if (fall_only) begin
          a_d     = 1'b0;
          state_d = LOW_HOLD;
          cnt_d   = LOW_LOAD;
        end
      end

      HIGH_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (fall_only) pend_d = 1'b1;
        end else if (pend_q || fall_only) begin
          // Pending or same-cycle fall executes right as the dwell ends.
          a_d     = 1'b0;
          state_d = LOW_HOLD;
          cnt_d   = LOW_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = HIGH_STABLE;
        end
      end

      LOW_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (rise_only) pend_d = 1'b1;
        end else if (pend_q || rise_only) begin
          a_d     = 1'b1;
          state_d = HIGH_HOLD;
          cnt_d   = HIGH_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = LOW_STABLE;
        end
      end

      default: begin
        state_d = LOW_STABLE;
        a_d     = 1'b0;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign bus.a_o    = a_q;
  assign bus.pend_o = pend_q;
  assign bus.drop_o = drop_q;
  assign bus.busy_o = (state_q == HIGH_HOLD) || (state_q == LOW_HOLD);

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen: per-cycle request vectors with hand-computed
// expected {a_o, busy_o, pend_o, drop_o}.
module tb_edge_gen;

  logic clk = 1'b0;
  logic reset;

  edge_gen_if bus ();

  edge_gen #(.MIN_HIGH(3), .MIN_LOW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Each entry: {rise, fall, exp_a, exp_busy, exp_pend, exp_drop}.
  // Expected bits describe the outputs in the cycle the request is driven.
  logic [5:0] vq[$];

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got {a,busy,pend,drop}=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.a_o, bus.busy_o, bus.pend_o, bus.drop_o};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    bus.rise_req_i = 1'b0;
    bus.fall_req_i = 1'b0;
    @(posedge clk);
    #1;
    check("in_reset", outs(), 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run(input string name);
    foreach (vq[i]) begin
      check($sformatf("%s c%0d", name, i), outs(), vq[i][3:0]);
      bus.rise_req_i = vq[i][5];
      bus.fall_req_i = vq[i][4];
      @(posedge clk);
      #1;
    end
    bus.rise_req_i = 1'b0;
    bus.fall_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Idle, plus a redundant fall in LOW_STABLE that must not drop.
    vq = '{6'b00_0000, 6'b00_0000, 6'b01_0000, 6'b00_0000, 6'b00_0000};
    run("idle");

    apply_reset();
    vq = '{6'b10_0000, 6'b00_1100, 6'b00_1100, 6'b00_1100, 6'b00_1000, 6'b00_1000};
    run("rise");

    // Extra fall at c2 is absorbed while pending is already set.
    apply_reset();
    vq = '{6'b10_0000, 6'b01_1100, 6'b01_1110, 6'b00_1110,
           6'b00_0100, 6'b00_0100, 6'b00_0000, 6'b00_0000};
    run("rise_fall");

    apply_reset();
    vq = '{6'b10_0000, 6'b00_1100, 6'b10_1100, 6'b00_1100, 6'b00_1000,
           6'b00_1000, 6'b00_1000, 6'b00_1000, 6'b00_1000, 6'b00_1000,
           6'b01_1000, 6'b00_0100, 6'b00_0100, 6'b00_0000};
    run("rerise");

    apply_reset();
    vq = '{6'b11_0000, 6'b00_0001, 6'b00_0000, 6'b00_0000};
    run("both_low");

    // Simultaneous pair while a fall is pending: drop, pending still fires on time.
    apply_reset();
    vq = '{6'b10_0000, 6'b01_1100, 6'b11_1110, 6'b00_1111,
           6'b00_0100, 6'b00_0100, 6'b00_0000};
    run("both_pend");

    // Fall on the last dwell cycle executes without passing through pend_o.
    apply_reset();
    vq = '{6'b10_0000, 6'b00_1100, 6'b00_1100, 6'b01_1100,
           6'b00_0100, 6'b00_0100, 6'b00_0000};
    run("fall_last");

    // Rise pending during the low dwell.
    apply_reset();
    vq = '{6'b10_0000, 6'b00_1100, 6'b00_1100, 6'b00_1100, 6'b01_1000,
           6'b10_0100, 6'b00_0110, 6'b00_1100, 6'b00_1100, 6'b00_1100,
           6'b00_1000};
    run("low_pend");

    // Async reset mid-dwell with a pending fall latched.
    apply_reset();
    vq = '{6'b10_0000, 6'b01_1100, 6'b00_1110};
    run("pre_rst");
    reset = 1'b1;
    #2;
    check("async_rst", outs(), 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vq = '{6'b00_0000, 6'b00_0000, 6'b00_0000, 6'b00_0000, 6'b00_0000};
    run("post_rst");
    vq = '{6'b10_0000, 6'b00_1100, 6'b00_1100, 6'b00_1100, 6'b00_1000, 6'b00_1000};
    run("rst_rise");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_gen.md
Name: edge_gen

Overview:
- Serial level generator, the transmit-side counterpart of the team's edge detector.
- Takes one-cycle rise/fall request pulses and drives a registered serial level `a_o`.
- Enforces minimum high and low dwell times so a downstream edge detector always sees clean, separable edges.
- Sits between control logic and any serial line sampled by an edge detector.

Parameters:
- MIN_HIGH, default 3: minimum consecutive cycles `a_o` stays 1 after a rise; legal range ≥1.
- MIN_LOW, default 2: minimum consecutive cycles `a_o` stays 0 after a fall; legal range ≥1.
- CNT_W, default $clog2(max(MIN_HIGH,MIN_LOW))+1: width of the dwell counter (derived, do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- rise_req_i  input  1  request to drive `a_o` high; single-cycle pulse.
- fall_req_i  input  1  request to drive `a_o` low; single-cycle pulse.
- a_o  output  1  serial level; registered.
- busy_o  output  1  high while a dwell period is running; combinational decode of state.
- pend_o  output  1  an opposite-direction request is latched and waiting; registered.
- drop_o  output  1  one-cycle pulse: a request was discarded; registered.

Behaviour:
- Reset (async, any time including mid-dwell):
  - state = LOW_STABLE, a_o = 0, counter = 0, pend_o = 0, drop_o = 0, busy_o = 0.
  - A latched pending request is lost on reset.
- States: LOW_STABLE, HIGH_HOLD, HIGH_STABLE, LOW_HOLD.
- busy_o = 1 exactly in HIGH_HOLD and LOW_HOLD.
- LOW_STABLE:
  - rise_req_i alone: a_o <= 1; go to HIGH_HOLD; counter <= MIN_HIGH-1.
  - fall_req_i alone: redundant; ignored with no drop.
- HIGH_STABLE: mirror of LOW_STABLE.
  - fall_req_i alone: a_o <= 0; go to LOW_HOLD; counter <= MIN_LOW-1.
  - rise_req_i alone: ignored with no drop.
- HIGH_HOLD:
  - counter != 0: counter decrements.
  - fall_req_i sets pend_o <= 1.
  - rise_req_i is ignored.
  - counter == 0: effective pending = pend_o | fall_req_i.
    - If set: a_o <= 0, go to LOW_HOLD, counter <= MIN_LOW-1, pend_o <= 0.
    - Else: go to HIGH_STABLE.
- LOW_HOLD: identical to HIGH_HOLD with directions and MIN_LOW/MIN_HIGH swapped.
- Latency and dwell timing:
  - A request accepted in a STABLE state in cycle t gives the a_o change visible at t+1.
  - a_o then holds for exactly MIN_x cycles if a pending request exists by the dwell's last cycle; otherwise it holds longer.
  - A pending request executes the cycle after the dwell ends, so back-to-back dwell is exact: MIN_HIGH high, then MIN_LOW low.
- Pending depth is one:
  - A further opposite request while pend_o = 1 is absorbed silently; no drop.
  - pend_o never holds a same-direction request.
- Simultaneous rise_req_i & fall_req_i in any state:
  - Both are discarded; drop_o = 1 the next cycle.
  - State, counter, a_o and pend_o are unchanged, except the counter still decrements in HOLD.
  - An already-latched pend_o still executes on schedule.
- drop_o is high for one cycle per discarded request pair; it does not stick.
- a_o changes only on clk edges (glitch-free).

Test Plan:
- Reset then idle 5 cycles -> a_o = 0, busy_o = 0, pend_o = 0, drop_o = 0 throughout.
- rise_req_i pulse at cycle 10 with no further requests -> a_o = 1 from cycle 11 onward; busy_o = 1 in cycles 11–13; state HIGH_STABLE from 14.
- rise at 10, fall at 11 -> pend_o = 1 from 12; a_o high cycles 11–13, a_o = 0 at 14; low dwell 14–15; busy_o drops at 16.
- rise at 10, rise at 12, fall at 20 (HIGH_STABLE) -> second rise ignored, no drop; a_o falls at cycle 21.
- rise_req_i & fall_req_i together at cycle 10 in LOW_STABLE -> a_o stays 0; drop_o = 1 at cycle 11 only.
- rise at 10, fall at 11, reset asserted at cycle 12 -> immediate a_o = 0, pend_o = 0, busy_o = 0; no fall edge executed after reset release; next rise behaves as in the second scenario.
